// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction ROM and hands words to decode over valid/ready.
// Define FETCH_BOUNDS_CHECK_EN to fault on PCs/targets beyond the last ROM word (misalignment always faults).
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic [31:0] rom_address,
    output logic        rom_read_enable,
    input  logic [31:0] rom_read_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fault,
    output logic        busy,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HALT,
        S_FAULT
    } state_e;

    if (RESET_PC[1:0] != 2'b00 || (ROM_BYTES % 4) != 0 || ROM_BYTES < 4) begin : g_bad_params
        $error("inst_fetch_unit: RESET_PC must be word-aligned and ROM_BYTES a non-zero multiple of 4");
    end

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic accept;
    logic stage_free;
    logic take_redirect;
    logic redirect_err;
    logic pc_err;
    logic read_en;

    assign accept        = inst_valid_q & inst_ready;
    assign stage_free    = ~inst_valid_q | inst_ready;
    assign take_redirect = redirect_valid && (state_q inside {S_FETCH, S_DRAIN, S_HALT});

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] LAST_WORD = 32'(ROM_BYTES - 4);

    // Out-of-range PC faults at the point a read would be issued, so a stalled last word still drains.
    assign redirect_err = take_redirect && ((redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_WORD));
    assign pc_err       = (state_q == S_FETCH) && stage_free && (pc_q > LAST_WORD);
`else
    assign redirect_err = take_redirect && (redirect_pc[1:0] != 2'b00);
    assign pc_err       = 1'b0;
`endif

    assign read_en = (state_q == S_FETCH) && stage_free && !pc_err;

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        inst_valid_d  = inst_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q + {31'd0, accept};

        if (accept) begin
            inst_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (halt_req) state_d = S_DRAIN;
            S_DRAIN: if (!inst_valid_q || accept) state_d = S_HALT;
            S_HALT:  if (start) state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // Faults beat redirects, and redirects beat captures.
        if (redirect_err || (pc_err && !take_redirect)) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            inst_valid_d = 1'b0;
        end else if (take_redirect) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
        end else if (read_en) begin
            inst_d       = rom_read_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            inst_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            inst_valid_q  <= inst_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign rom_address     = pc_q;
    assign rom_read_enable = read_en;
    assign inst            = inst_q;
    assign inst_pc         = inst_pc_q;
    assign inst_valid      = inst_valid_q;
    assign fault           = fault_q;
    assign busy            = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: scoreboard of expected decode-side words plus directed status checks.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [31:0] rom_address;
    logic        rom_read_enable;
    logic [31:0] rom_read_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fault;
    logic        busy;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ROM_BYTES(256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .rom_address    (rom_address),
        .rom_read_enable(rom_read_enable),
        .rom_read_data  (rom_read_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .busy           (busy),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2001_0005;
        else if (a == 32'h4) return 32'h2002_0007;
        else                 return 32'hC000_0000 | a;
    endfunction

    always_comb rom_read_data = rom_word(rom_address);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] a);
        exp_t e;
        e.word = rom_word(a);
        e.pc   = a;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_inst_valid"}, inst_valid, 0);
        check({tag, "_inst"}, inst, 0);
        check({tag, "_inst_pc"}, inst_pc, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fetch_count"}, fetch_count, 0);
        check({tag, "_rom_re"}, rom_read_enable, 0);
        check({tag, "_rom_addr"}, rom_address, 32'h0);
    endtask

    // Scoreboard: every accepted word must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_inst", inst, e.word);
                check("sb_inst_pc", inst_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        rst_n          = 1'b0;
        start          = 1'b0;
        halt_req       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #12;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Start and first two words
        step();
        start      = 1'b1;
        inst_ready = 1'b1;
        push_word(32'h0);
        push_word(32'h4);
        step();
        start = 1'b0;
        #1;
        check("start_busy", busy, 1);
        check("start_not_valid_yet", inst_valid, 0);
        check("start_rom_re", rom_read_enable, 1);
        step();
        check("first_valid_after_2_edges", inst_valid, 1);
        check("first_inst", inst, 32'h2001_0005);
        step();
        check("second_inst_pc", inst_pc, 32'h4);

        // Stall three cycles
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_inst", inst, 32'h2002_0007);
            check("stall_inst_pc", inst_pc, 32'h4);
            check("stall_rom_re", rom_read_enable, 0);
            check("stall_pc", rom_address, 32'h8);
        end
        inst_ready = 1'b1;
        push_word(32'h8);
        step();
        check("after_stall_count", fetch_count, 2);
        check("after_stall_next_pc", inst_pc, 32'h8);

        // Redirect while a word is being accepted
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        push_word(32'h40);
        #1;
        check("redirect_flush", inst_valid, 0);
        check("redirect_count_includes_accept", fetch_count, 3);
        check("redirect_rom_addr", rom_address, 32'h40);
        check("redirect_rom_re", rom_read_enable, 1);
        step();
        check("redirect_target_valid", inst_valid, 1);
        check("redirect_target_pc", inst_pc, 32'h40);

        // Halt while the output stage is stalled
        inst_ready = 1'b0;
        halt_req   = 1'b1;
        step();
        #1;
        check("drain_busy", busy, 1);
        check("drain_holds_valid", inst_valid, 1);
        check("drain_holds_pc", inst_pc, 32'h40);
        check("drain_no_read", rom_read_enable, 0);
        step();
        check("drain_still_busy", busy, 1);
        inst_ready = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_busy", busy, 0);
        check("halt_valid", inst_valid, 0);
        check("halt_pc_retained", rom_address, 32'h44);
        check("halt_count", fetch_count, 4);
        step();
        check("halt_no_read", rom_read_enable, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        push_word(32'h44);
        check("resume_busy", busy, 1);
        step();
        check("resume_inst_pc", inst_pc, 32'h44);

        // Misaligned redirect faults and sticks
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("misalign_fault", fault, 1);
        check("misalign_valid", inst_valid, 0);
        check("misalign_busy", busy, 0);
        check("misalign_pc_kept", rom_address, 32'h48);
        check("misalign_count", fetch_count, 5);
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        start          = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("fault_sticky", fault, 1);
        check("fault_ignores_redirect", rom_address, 32'h48);
        check("fault_no_read", rom_read_enable, 0);
        check("fault_ignores_start", busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("fault_reset");
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Sequential run to the end of the ROM
        step();
        start      = 1'b1;
        inst_ready = 1'b1;
        for (int a = 0; a <= 32'hFC; a += 4) push_word(32'(a));
`ifndef FETCH_BOUNDS_CHECK_EN
        push_word(32'h100);
`endif
        step();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (inst_valid && inst_pc == 32'hFC) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_last_word", found, 1);
        step();
        check("end_count", fetch_count, 64);
`ifdef FETCH_BOUNDS_CHECK_EN
        check("bounds_fault", fault, 1);
        check("bounds_valid", inst_valid, 0);
        check("bounds_no_read", rom_read_enable, 0);
        check("bounds_pc", rom_address, 32'h100);
`else
        check("nobounds_fault", fault, 0);
        check("nobounds_valid", inst_valid, 1);
        check("nobounds_inst_pc", inst_pc, 32'h100);
        check("nobounds_inst", inst, 32'hC000_0100);
`endif

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

- Fetch-side initiator for the byte-addressed, big-endian instruction ROM.
- Owns the program counter and drives the ROM's 32-bit address and read-enable.
- Captures the 4-byte instruction word into a registered output stage and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects, halt requests and address faults between the ROM and the decode stage of the CPU.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- ROM_BYTES, 256, ROM depth in bytes; multiple of 4.

Ports:
- Clock and reset:
  - clk  in  1  single clock; all state updates on rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
- Control:
  - start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
  - halt_req  in  1  level; stop issuing new fetches.
- ROM side:
  - rom_address  out  32  byte address to ROM; equals pc.
  - rom_read_enable  out  1  ROM read enable.
  - rom_read_data  in  32  ROM word; combinational from rom_address.
- Decode side:
  - inst  out  32  captured instruction word.
  - inst_pc  out  32  address the word was fetched from.
  - inst_valid  out  1  inst/inst_pc hold a valid instruction.
  - inst_ready  in  1  decode accepts inst this cycle.
- Redirect:
  - redirect_valid  in  1  branch/jump taken this cycle.
  - redirect_pc  in  32  target address.
- Status:
  - fault  out  1  sticky address fault.
  - busy  out  1  high in FETCH or DRAIN.
  - fetch_count  out  32  count of accepted instructions (inst_valid & inst_ready).

## Operation

State machine:
- States: IDLE, FETCH, DRAIN, HALT, FAULT.
- IDLE -> FETCH on start.
- FETCH -> DRAIN on halt_req.
- DRAIN -> HALT once inst_valid is 0, or inst_valid & inst_ready.
- HALT -> FETCH on start; pc is retained.
- Any state except IDLE -> FAULT on an address error.
- FAULT is left only by reset.

ROM interface:
- rom_address = pc in all states.
- rom_read_enable = 1 only in FETCH and only when output stage is free (inst_valid==0 or inst_ready==1).

Capture:
- When rom_read_enable is 1 and no redirect: inst<=rom_read_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (32-bit wrap).
- Output stage holds while inst_valid & !inst_ready: inst, inst_pc and pc stable; no ROM read.
- With inst_valid & inst_ready, and no new capture: inst_valid<=0.

Redirect (highest priority, accepted in FETCH, DRAIN and HALT):
- pc<=redirect_pc, inst_valid<=0 (flush), no capture that cycle.
- Redirect in IDLE is ignored.

Address errors:
- redirect_pc[1:0]!=0: enter FAULT, fault<=1, inst_valid<=0; pc is not updated.
- Bounds errors per Configuration.

fetch_count:
- Increments by 1 on each inst_valid & inst_ready, wrapping at 2^32.
- The count includes the accepting cycle, even if a redirect occurs in that same cycle.

Simultaneous events:
- Redirect + halt_req: redirect applied, state -> DRAIN.
- start while in FETCH: ignored.

## Timing

Reset values:
- pc=RESET_PC, state=IDLE
- inst=0, inst_pc=0, inst_valid=0
- fault=0, busy=0, fetch_count=0
- rom_read_enable=0

Latency and throughput:
- start pulse at edge N -> rom_read_enable high in cycle N+1 -> inst_valid high after edge N+2.
- Sustained throughput one instruction per cycle while inst_ready=1.
- Redirect at edge M: first word from redirect_pc is valid after edge M+1; exactly one bubble.

Reset mid-operation:
- Assertion of rst_n immediately forces all reset values, regardless of clk.
- A pending inst is discarded.

## Configuration

FETCH_BOUNDS_CHECK_EN:
- Defined:
  - Any pc or redirect_pc greater than ROM_BYTES-4 enters FAULT before a ROM read is issued.
  - Sequential increment past the last word also faults.
- Undefined:
  - No bounds check; pc increments freely.
  - Only misalignment faults.

## Test plan

- Reset then start, ROM words 0x20010005, 0x20020007 at 0x00/0x04, inst_ready=1: inst_valid after 2 edges, inst=0x20010005 / inst_pc=0 then 0x20020007 / inst_pc=4; fetch_count=2.
- inst_ready held 0 for 3 cycles with inst_valid=1: inst/inst_pc stable, rom_read_enable=0, pc unchanged; release -> next word follows in 1 cycle.
- redirect_valid with redirect_pc=0x40 while inst_valid=1: inst_valid drops next cycle, then inst_pc=0x40; redirect_pc=0x42 -> fault=1, state FAULT, persists until rst_n low.
- halt_req during a stalled inst: DRAIN until accept, then HALT with busy=0; start resumes at retained pc.
- With FETCH_BOUNDS_CHECK_EN defined: run sequentially to 0xFC (ROM_BYTES=256) -> fault=1 on the attempted fetch of 0x100. Without the macro: inst_pc=0x100 is fetched and fault stays 0.
- rst_n asserted asynchronously mid-stream: all outputs at reset values before the next clk edge, fetch_count=0.
